// File: rtl/onehot_decoder_pipe_pkg.sv
// Shared types and helpers for the one-hot decoder pipe.
// The PARITY_CHECK_EN macro enables the parity-check variant of the block.
package onehot_dec_pkg;
  localparam int N_OUT_DEF  = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 16;
  // Codes are carried at a fixed max width so the FIFO entry type is shared
  localparam int MAX_CODE_W = 8;
  localparam int MAX_N      = 1 << MAX_CODE_W;

  typedef logic [MAX_CODE_W-1:0] code_t;

  typedef struct packed {
    logic  en;
    code_t code;
  } fifo_entry_t;

  function automatic logic [MAX_N-1:0] onehot_of(input logic en, input code_t code);
    logic [MAX_N-1:0] v;
    v = '0;
    if (en) v[code] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/onehot_decoder_pipe_if.sv
// Input/output handshake bundle of the one-hot decoder pipe.
// The PARITY_CHECK_EN macro adds the in_par signal.
interface onehot_decoder_pipe_if #(parameter int N_OUT = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_en;
  logic [$clog2(N_OUT)-1:0] in_code;
`ifdef PARITY_CHECK_EN
  logic                     in_par;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [N_OUT-1:0]         out_onehot;

  modport master (
    output in_valid, in_en, in_code, out_ready,
`ifdef PARITY_CHECK_EN
    output in_par,
`endif
    input  in_ready, out_valid, out_onehot
  );

  modport slave (
    input  in_valid, in_en, in_code, out_ready,
`ifdef PARITY_CHECK_EN
    input  in_par,
`endif
    output in_ready, out_valid, out_onehot
  );
endinterface

// File: rtl/onehot_decoder_pipe_fifo.sv
// Input FIFO for the decoder: circular storage with registered full flag.
// The occupancy count is one bit wider than the pointers to separate full from empty.
module dec_fifo
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  fifo_entry_t i_wdata,
  output fifo_entry_t o_rdata,
  output logic        o_full,
  output logic        o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_cnt;
  logic [PTR_W:0]   w_cnt_nxt;
  logic             r_full;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({i_push, i_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == (PTR_W+1)'(DEPTH));
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/onehot_decoder_pipe.sv
// Buffered valid/ready binary-to-one-hot decoder with saturating per-line hit counters.
// Define PARITY_CHECK_EN to add even-parity screening of pushed items (in_par, par_err).
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  onehot_decoder_pipe_if.slave     bus,
  input  logic                     cnt_clr,
  input  logic [$clog2(N_OUT)-1:0] cnt_sel,
  output logic [CNT_W-1:0]         cnt_val
`ifdef PARITY_CHECK_EN
  ,
  output logic                     par_err
`endif
);
  fifo_entry_t w_wdata, w_head;
  logic        w_full, w_empty, w_push, w_store, w_load, w_hs;
  logic        r_alive, r_out_valid;
  logic [N_OUT-1:0]            r_onehot;
  logic [N_OUT-1:0][CNT_W-1:0] r_cnt;

  assign w_push  = bus.in_valid && bus.in_ready;
  assign w_wdata = '{en: bus.in_en, code: code_t'(bus.in_code)};

`ifdef PARITY_CHECK_EN
  logic w_par_ok;
  assign w_par_ok = ~^{bus.in_par, bus.in_en, bus.in_code};
  // Bad-parity items still complete the handshake; they are just not stored
  assign w_store  = w_push && w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     par_err <= 1'b0;
    else if (cnt_clr)               par_err <= 1'b0;
    else if (w_push && !w_par_ok)   par_err <= 1'b1;
  end
`else
  assign w_store = w_push;
`endif

  assign w_load = !w_empty && (!r_out_valid || bus.out_ready);
  assign w_hs   = r_out_valid && bus.out_ready;

  dec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_store),
    .i_pop   (w_load),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Holds in_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_onehot    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_onehot    <= N_OUT'(onehot_of(w_head.en, w_head.code));
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt[i] <= '0;
      else if (cnt_clr)
        r_cnt[i] <= '0;
      else if (w_hs && r_onehot[i] && (r_cnt[i] != {CNT_W{1'b1}}))
        r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign bus.in_ready   = r_alive && !w_full;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_onehot = r_onehot;
  assign cnt_val        = r_cnt[cnt_sel];
endmodule
